// File: rtl/wait_data_mem.sv
// wait_data_mem: word-organised data memory with a waitrequest handshake,
// per-byte write enables, a fixed number of stall cycles per access and
// address checking. It stands in for a zero-latency RAM on the CPU data bus
// so the CPU can be stalled and partial-word stores can be exercised.
module wait_data_mem #(
    parameter string       DATA_INIT_FILE = "",
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter int unsigned DEPTH_WORDS    = 128,
    parameter int unsigned WAIT_CYCLES    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_byteenable,
    input  logic [31:0] data_writedata,
    output logic        data_waitrequest,
    output logic [31:0] data_readdata,
    output logic        data_err
);

    localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic          r_wr_pend;
    logic [AW-1:0] r_wr_index;
    logic [31:0]   r_wr_data;
    logic [3:0]    r_wr_be;

    logic          w_req;
    logic [AW-1:0] w_index;
    logic          w_in_range;
    logic          w_legal;
    logic          w_enter_ack;

    // Memory starts all-zero.
    initial begin
        for (int i = 0; i < int'(DEPTH_WORDS); i++) r_mem[i] = '0;
    end

    assign w_req   = data_read | data_write;
    assign w_index = AW'((data_address - BASE_ADDR) >> 2);

    // Range check is done one bit wider so an end address at the top of the
    // 32-bit space cannot wrap around and look legal.
    assign w_in_range = ({1'b0, data_address} >= {1'b0, BASE_ADDR}) &&
                        ({1'b0, data_address} <  END_ADDR);
    assign w_legal    = (data_address[1:0] == 2'b00) && w_in_range &&
                        !(data_read && data_write);

    assign w_enter_ack = w_req &&
                         (((r_state == S_IDLE) && (WAIT_CYCLES == 0)) ||
                          ((r_state == S_BUSY) && (r_cnt == 4'd0)));

    // The master must see a stall while the memory is held in reset.
    assign data_waitrequest = ~rst_n | (w_req & (r_state != S_ACK));

    // Access sequencer: IDLE -> BUSY (stall countdown) -> ACK -> IDLE.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (WAIT_CYCLES == 0) begin
                            r_state <= S_ACK;
                        end else begin
                            r_state <= S_BUSY;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                S_BUSY: begin
                    if (!w_req) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_state <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ACK:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Capture read data, error flag and the pending write when entering ACK;
    // the write itself lands on the edge that leaves ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_readdata <= 32'h0;
            data_err      <= 1'b0;
            r_wr_pend     <= 1'b0;
            r_wr_index    <= '0;
            r_wr_data     <= 32'h0;
            r_wr_be       <= 4'h0;
        end else if (w_enter_ack) begin
            data_readdata <= w_legal ? r_mem[w_index] : BAD_DATA;
            data_err      <= ~w_legal;
            r_wr_pend     <= w_legal & data_write;
            r_wr_index    <= w_index;
            r_wr_data     <= data_writedata;
            r_wr_be       <= data_byteenable;
        end else if (r_state == S_ACK) begin
            data_err  <= 1'b0;
            r_wr_pend <= 1'b0;
        end
    end

    // Byte-lane write commit on ACK exit.
    // NOTE: the storage array has no reset; contents must survive rst_n.
    always_ff @(posedge clk) begin
        if ((r_state == S_ACK) && r_wr_pend) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wr_be[i]) r_mem[r_wr_index][8*i +: 8] <= r_wr_data[8*i +: 8];
            end
        end
    end

endmodule
